// File: rtl/accelerator_dnc_pkg.sv
// Shared types and constants for the DNC write-head interface vector splitter.
package accelerator_dnc_pkg;

  typedef enum logic [2:0] {
    STARTER_STATE,
    K_STATE,
    BETA_STATE,
    E_STATE,
    V_STATE,
    GA_STATE,
    GW_STATE
  } state_t;

  // Frame length is FIELD_COUNT*Sw + FIELD_COUNT (three vectors, three scalars).
  localparam int unsigned FIELD_COUNT = 3;

endpackage

// File: rtl/accelerator_interface_vector.sv
// Splits the serial write-head slice of xi into k, beta, e, v, ga and gw element streams.
module accelerator_interface_vector #(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64,
  parameter int W            = 64
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    ACCELERATOR_INTERFACE_VECTOR_START,
  output logic                    ACCELERATOR_INTERFACE_VECTOR_READY,
  input  logic [CONTROL_SIZE-1:0] ACCELERATOR_INTERFACE_VECTOR_SIZE_W_IN,
  input  logic                    ACCELERATOR_INTERFACE_VECTOR_XI_IN_ENABLE,
  input  logic [DATA_SIZE-1:0]    ACCELERATOR_INTERFACE_VECTOR_XI_IN,
  output logic                    ACCELERATOR_INTERFACE_VECTOR_K_OUT_ENABLE,
  output logic [DATA_SIZE-1:0]    ACCELERATOR_INTERFACE_VECTOR_K_OUT,
  output logic                    ACCELERATOR_INTERFACE_VECTOR_BETA_OUT_ENABLE,
  output logic [DATA_SIZE-1:0]    ACCELERATOR_INTERFACE_VECTOR_BETA_OUT,
  output logic                    ACCELERATOR_INTERFACE_VECTOR_E_OUT_ENABLE,
  output logic [DATA_SIZE-1:0]    ACCELERATOR_INTERFACE_VECTOR_E_OUT,
  output logic                    ACCELERATOR_INTERFACE_VECTOR_V_OUT_ENABLE,
  output logic [DATA_SIZE-1:0]    ACCELERATOR_INTERFACE_VECTOR_V_OUT,
  output logic                    ACCELERATOR_INTERFACE_VECTOR_GA_OUT_ENABLE,
  output logic [DATA_SIZE-1:0]    ACCELERATOR_INTERFACE_VECTOR_GA_OUT,
  output logic                    ACCELERATOR_INTERFACE_VECTOR_GW_OUT_ENABLE,
  output logic [DATA_SIZE-1:0]    ACCELERATOR_INTERFACE_VECTOR_GW_OUT
);
  import accelerator_dnc_pkg::*;

  typedef logic [CONTROL_SIZE-1:0] ctrl_t;
  localparam ctrl_t W_C = ctrl_t'(W);

  localparam int unsigned F_K    = 0;
  localparam int unsigned F_BETA = 1;
  localparam int unsigned F_E    = 2;
  localparam int unsigned F_V    = 3;
  localparam int unsigned F_GA   = 4;
  localparam int unsigned F_GW   = 5;

  state_t               state_q, state_d;
  ctrl_t                cnt_q, cnt_d;
  ctrl_t                sw_q, sw_d;
  logic [5:0]           en_q, en_d;
  logic                 ready_q, ready_d;
  logic [DATA_SIZE-1:0] data_q [6];
  logic [DATA_SIZE-1:0] data_d [6];

  logic                 xi_en;
  logic                 last_elem;
  logic                 accept;
  int unsigned          sel;

  assign xi_en     = ACCELERATOR_INTERFACE_VECTOR_XI_IN_ENABLE;
  assign last_elem = (cnt_q == sw_q - ctrl_t'(1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sw_d    = sw_q;
    en_d    = '0;
    ready_d = 1'b0;
    data_d  = data_q;
    accept  = 1'b0;
    sel     = F_K;

    case (state_q)
      STARTER_STATE: begin
        if (ACCELERATOR_INTERFACE_VECTOR_START) begin
          sw_d    = (ACCELERATOR_INTERFACE_VECTOR_SIZE_W_IN > W_C) ? W_C
                                                                   : ACCELERATOR_INTERFACE_VECTOR_SIZE_W_IN;
          cnt_d   = '0;
          state_d = (sw_d != '0) ? K_STATE : BETA_STATE;
        end
      end
      K_STATE, E_STATE, V_STATE: begin
        sel    = (state_q == K_STATE) ? F_K : (state_q == E_STATE) ? F_E : F_V;
        accept = xi_en;
        if (xi_en) begin
          if (last_elem) begin
            cnt_d   = '0;
            state_d = (state_q == K_STATE) ? BETA_STATE :
                      (state_q == E_STATE) ? V_STATE : GA_STATE;
          end else begin
            cnt_d = cnt_q + ctrl_t'(1);
          end
        end
      end
      BETA_STATE: begin
        sel    = F_BETA;
        accept = xi_en;
        // With Sw = 0 every vector field is empty, so beta hands straight to ga.
        if (xi_en) state_d = (sw_q == '0) ? GA_STATE : E_STATE;
      end
      GA_STATE: begin
        sel    = F_GA;
        accept = xi_en;
        if (xi_en) state_d = GW_STATE;
      end
      GW_STATE: begin
        sel    = F_GW;
        accept = xi_en;
        if (xi_en) begin
          state_d = STARTER_STATE;
          ready_d = 1'b1;
        end
      end
      default: state_d = STARTER_STATE;
    endcase

    if (accept) begin
      en_d[sel]   = 1'b1;
      data_d[sel] = ACCELERATOR_INTERFACE_VECTOR_XI_IN;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= STARTER_STATE;
      cnt_q   <= '0;
      sw_q    <= '0;
      en_q    <= '0;
      ready_q <= 1'b0;
      for (int unsigned i = 0; i < 6; i++) data_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sw_q    <= sw_d;
      en_q    <= en_d;
      ready_q <= ready_d;
      for (int unsigned i = 0; i < 6; i++) data_q[i] <= data_d[i];
    end
  end

  assign ACCELERATOR_INTERFACE_VECTOR_READY           = ready_q;
  assign ACCELERATOR_INTERFACE_VECTOR_K_OUT_ENABLE    = en_q[F_K];
  assign ACCELERATOR_INTERFACE_VECTOR_K_OUT           = data_q[F_K];
  assign ACCELERATOR_INTERFACE_VECTOR_BETA_OUT_ENABLE = en_q[F_BETA];
  assign ACCELERATOR_INTERFACE_VECTOR_BETA_OUT        = data_q[F_BETA];
  assign ACCELERATOR_INTERFACE_VECTOR_E_OUT_ENABLE    = en_q[F_E];
  assign ACCELERATOR_INTERFACE_VECTOR_E_OUT           = data_q[F_E];
  assign ACCELERATOR_INTERFACE_VECTOR_V_OUT_ENABLE    = en_q[F_V];
  assign ACCELERATOR_INTERFACE_VECTOR_V_OUT           = data_q[F_V];
  assign ACCELERATOR_INTERFACE_VECTOR_GA_OUT_ENABLE   = en_q[F_GA];
  assign ACCELERATOR_INTERFACE_VECTOR_GA_OUT          = data_q[F_GA];
  assign ACCELERATOR_INTERFACE_VECTOR_GW_OUT_ENABLE   = en_q[F_GW];
  assign ACCELERATOR_INTERFACE_VECTOR_GW_OUT          = data_q[F_GW];

endmodule
